// File: rtl/sparse_pkg.sv
// Shared types and sizes for the 2:4 structured-sparse matrix-vector engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sparse_pkg;

  localparam int NUM_ROWS = 4;
  localparam int VEC_LEN  = 4;
  localparam int DATA_W   = 8;
  localparam int IDX_W    = $clog2(VEC_LEN);
  localparam int PSUM_W   = 20;
  // One 8x8 signed product, and the exact sum of two of them.
  localparam int PROD_W   = 2 * DATA_W;
  localparam int SUM_W    = PROD_W + 1;

  // One compressed weight row: two non-zero weights plus their column positions.
  typedef struct packed {
    logic signed [DATA_W-1:0] val_0;
    logic signed [DATA_W-1:0] val_1;
    logic        [IDX_W-1:0]  idx_0;
    logic        [IDX_W-1:0]  idx_1;
  } sparse_packet_t;

  typedef logic signed [DATA_W-1:0] act_t;
  typedef act_t activation_vec_t [VEC_LEN];

endpackage

// File: rtl/sparse_row_mac.sv
// One row of the sparse engine: picks the two activations named by the row's
// indices, registers both products, and adds them (sum_o comes straight off the
// product registers). Latency: 1 enabled cycle to sum_o. Backpressure: none; en stalls.
// Ports: aclk/aresetn clock and async active-low reset; en advance enable;
//        pkt_i compressed weight row; act_i dense activations; sum_o exact 17-bit sum.
module sparse_row_mac
  import sparse_pkg::*;
(
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    en,
  input  sparse_packet_t          pkt_i,
  input  activation_vec_t         act_i,
  output logic signed [SUM_W-1:0] sum_o
);

  logic signed [PROD_W-1:0] prod0_d, prod1_d;
  logic signed [PROD_W-1:0] prod0_q, prod1_q;

  always_comb begin
    prod0_d = PROD_W'(pkt_i.val_0) * PROD_W'(act_i[pkt_i.idx_0]);
    prod1_d = PROD_W'(pkt_i.val_1) * PROD_W'(act_i[pkt_i.idx_1]);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      prod0_q <= '0;
      prod1_q <= '0;
    end else if (en) begin
      prod0_q <= prod0_d;
      prod1_q <= prod1_d;
    end
  end

  // One extra bit keeps the worst case (-128*-128)*2 = 32768 exact.
  assign sum_o = SUM_W'(prod0_q) + SUM_W'(prod1_q);

endmodule

// File: rtl/sparse_core_unit.sv
// 2:4 structured-sparse matrix-vector multiply: NUM_ROWS rows of two int8 weights
// against a dense int8 vector, one signed PSUM_W partial sum per row.
// Latency: 2 enabled cycles. Backpressure: none; en=0 freezes every stage.
// Ports: aclk/aresetn clock and async active-low reset; en pipeline advance;
//        w_rows compressed weight rows; act_vec dense activations; psum_out row results.
// Build option: SPARSE_CORE_ACCUM_EN makes the output stage accumulate (wrapping)
// instead of overwrite, restarting from the current sum on each en rising edge.
module sparse_core_unit
  import sparse_pkg::*;
(
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     en,
  input  sparse_packet_t           w_rows  [NUM_ROWS],
  input  activation_vec_t          act_vec,
  output logic signed [PSUM_W-1:0] psum_out [NUM_ROWS]
);

  logic signed [SUM_W-1:0]  sum_w  [NUM_ROWS];
  logic signed [PSUM_W-1:0] psum_d [NUM_ROWS];
  logic signed [PSUM_W-1:0] psum_q [NUM_ROWS];

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    sparse_row_mac u_mac (
      .aclk    (aclk),
      .aresetn (aresetn),
      .en      (en),
      .pkt_i   (w_rows[r]),
      .act_i   (act_vec),
      .sum_o   (sum_w[r])
    );
  end

`ifdef SPARSE_CORE_ACCUM_EN
  // Tracks en on every edge (not gated) so the first enabled edge after a
  // low period can be recognised and the accumulator restarted.
  logic en_prev_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) en_prev_q <= 1'b0;
    else          en_prev_q <= en;
  end

  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      psum_d[r] = en_prev_q ? psum_q[r] + PSUM_W'(sum_w[r]) : PSUM_W'(sum_w[r]);
    end
  end
`else
  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      psum_d[r] = PSUM_W'(sum_w[r]);
    end
  end
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int r = 0; r < NUM_ROWS; r++) psum_q[r] <= '0;
    end else if (en) begin
      for (int r = 0; r < NUM_ROWS; r++) psum_q[r] <= psum_d[r];
    end
  end

  assign psum_out = psum_q;

endmodule

// File: tb/tb_sparse_core_unit.sv
// Self-checking bench for sparse_core_unit: directed cases with literal results
// plus randomized traffic checked every cycle against a result-history model.
module tb_sparse_core_unit;
  import sparse_pkg::*;

  logic                     aclk;
  logic                     aresetn;
  logic                     en;
  sparse_packet_t           w_rows  [NUM_ROWS];
  activation_vec_t          act_vec;
  logic signed [PSUM_W-1:0] psum_out [NUM_ROWS];

  int n_tests = 0;
  int n_fail  = 0;

  sparse_core_unit dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .en       (en),
    .w_rows   (w_rows),
    .act_vec  (act_vec),
    .psum_out (psum_out)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Row result straight from the definition, in plain integer arithmetic.
  function automatic int row_result(input sparse_packet_t p, input activation_vec_t a);
    int v0, v1, a0, a1;
    v0 = int'($signed(p.val_0));
    v1 = int'($signed(p.val_1));
    a0 = int'($signed(a[int'(p.idx_0)]));
    a1 = int'($signed(a[int'(p.idx_1)]));
    return v0 * a0 + v1 * a1;
  endfunction

  // Model: the output is the result of the inputs taken at the previous enabled
  // edge (0 if none since reset); in accumulate builds that result is added to
  // the running total unless the previous cycle had en low.
  int  m_pending [NUM_ROWS];
  int  m_out     [NUM_ROWS];
  bit  m_en_prev;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        m_pending[r] <= 0;
        m_out[r]     <= 0;
      end
      m_en_prev <= 1'b0;
    end else begin
      if (en) begin
        for (int r = 0; r < NUM_ROWS; r++) begin
`ifdef SPARSE_CORE_ACCUM_EN
          m_out[r] <= m_en_prev ? wrap20(m_out[r] + m_pending[r]) : m_pending[r];
`else
          m_out[r] <= m_pending[r];
`endif
          m_pending[r] <= row_result(w_rows[r], act_vec);
        end
      end
      m_en_prev <= en;
    end
  end

  function automatic int wrap20(input int v);
    logic signed [PSUM_W-1:0] t;
    t = PSUM_W'(v);
    return int'(t);
  endfunction

  // Every cycle, away from the active edge.
  always @(negedge aclk) begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      n_tests++;
      if (int'(psum_out[r]) !== m_out[r]) begin
        n_fail++;
        $display("FAIL model_row%0d t=%0t: got %0d expected %0d", r, $time, int'(psum_out[r]), m_out[r]);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  function automatic sparse_packet_t mk(input int v0, input int i0, input int v1, input int i1);
    sparse_packet_t p;
    p.val_0 = DATA_W'(v0);
    p.idx_0 = IDX_W'(i0);
    p.val_1 = DATA_W'(v1);
    p.idx_1 = IDX_W'(i1);
    return p;
  endfunction

  function automatic sparse_packet_t rnd_pkt();
    return mk(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
  endfunction

  task automatic set_act(input int a0, input int a1, input int a2, input int a3);
    act_vec[0] = DATA_W'(a0);
    act_vec[1] = DATA_W'(a1);
    act_vec[2] = DATA_W'(a2);
    act_vec[3] = DATA_W'(a3);
  endtask

  task automatic all_rows(input sparse_packet_t p);
    for (int r = 0; r < NUM_ROWS; r++) w_rows[r] = p;
  endtask

  initial begin
    aresetn = 1'b0;
    en      = 1'b0;
    all_rows(mk(0, 0, 0, 0));
    set_act(0, 0, 0, 0);
    repeat (3) step();
    for (int r = 0; r < NUM_ROWS; r++) chk($sformatf("reset_row%0d", r), int'(psum_out[r]), 0);
    aresetn = 1'b1;

    // Pin the reference function against hand-computed values.
    set_act(1, 2, 3, 4);
    chk("model_basic", row_result(mk(5, 0, -3, 3), act_vec), -7);
    set_act(-128, -128, -128, -128);
    chk("model_max", row_result(mk(-128, 1, -128, 2), act_vec), 32768);

`ifndef SPARSE_CORE_ACCUM_EN
    // Basic row.
    set_act(1, 2, 3, 4);
    all_rows(rnd_pkt());
    w_rows[0] = mk(5, 0, -3, 3);
    en = 1'b1;
    step();
    step();
    chk("basic_row0", int'(psum_out[0]), -7);

    // Extremes.
    set_act(-128, -128, -128, -128);
    all_rows(mk(-128, 0, -128, 3));
    step();
    step();
    for (int r = 0; r < NUM_ROWS; r++) chk($sformatf("max_pos_row%0d", r), int'(psum_out[r]), 32768);
    all_rows(mk(127, 1, 127, 2));
    step();
    step();
    for (int r = 0; r < NUM_ROWS; r++) chk($sformatf("max_neg_row%0d", r), int'(psum_out[r]), -32512);

    // Duplicate index.
    set_act(7, -9, 10, 3);
    w_rows[1] = mk(2, 2, 3, 2);
    step();
    step();
    chk("dup_idx_row1", int'(psum_out[1]), 50);

    // Hold with en low.
    set_act(1, 2, 3, 4);
    w_rows[0] = mk(5, 0, -3, 3);
    step();
    step();
    chk("hold_pre", int'(psum_out[0]), -7);
    en = 1'b0;
    set_act(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("hold_%0d", i), int'(psum_out[0]), -7);
    end
    en = 1'b1;
    step();
    chk("hold_release_1", int'(psum_out[0]), -7);
    step();
    chk("hold_release_2", int'(psum_out[0]), 0);

    // Reset mid-operation.
    en = 1'b0;
    set_act(1, 2, 3, 4);
    step();
    en = 1'b1;
    step();
    aresetn = 1'b0;
    #1;
    for (int r = 0; r < NUM_ROWS; r++) chk($sformatf("midrst_row%0d", r), int'(psum_out[r]), 0);
    step();
    aresetn = 1'b1;
    step();
    chk("after_rst_1", int'(psum_out[0]), 0);
    step();
    chk("after_rst_2", int'(psum_out[0]), -7);
`else
    // Accumulating output: constant row result of 10.
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    set_act(1, 1, 1, 1);
    all_rows(mk(5, 0, 5, 3));
    en = 1'b1;
    step();
    chk("acc_fill", int'(psum_out[0]), 0);
    step();
    chk("acc_10", int'(psum_out[0]), 10);
    step();
    chk("acc_20", int'(psum_out[0]), 20);
    step();
    chk("acc_30", int'(psum_out[0]), 30);
    en = 1'b0;
    step();
    step();
    chk("acc_hold", int'(psum_out[0]), 30);
    en = 1'b1;
    step();
    chk("acc_restart", int'(psum_out[0]), 10);
    step();
    chk("acc_restart_20", int'(psum_out[0]), 20);
`endif

    // Randomized traffic, checked by the per-cycle compare against the model.
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) < 7);
      for (int r = 0; r < NUM_ROWS; r++) w_rows[r] = rnd_pkt();
      for (int k = 0; k < VEC_LEN; k++) act_vec[k] = DATA_W'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) aresetn = 1'b0;
      else aresetn = 1'b1;
      step();
    end
    aresetn = 1'b1;
    en = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
